// File: rtl/data_cache_if.sv
// Bus bundle for the data cache: memory-stage load/store side plus the
// single-transaction main-memory side.
interface data_cache_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) ();
    // Memory-stage load lookup
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    // Memory-stage committed store
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    // Main-memory transaction
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // Cache side
    modport slave (
        input  rd_req, rd_addr,
        output rd_ready, rd_data,
        input  wr_req, wr_addr, wr_data,
        output wr_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    // Requester / memory side
    modport master (
        output rd_req, rd_addr,
        input  rd_ready, rd_data,
        output wr_req, wr_addr, wr_data,
        input  wr_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/data_cache.sv
// Blocking direct-mapped, write-through, no-write-allocate data cache.
// Loads hit combinationally from registered state; misses fill one word per
// memory beat. Only one memory transaction is ever outstanding.
// LINE_WORDS and SETS are assumed to be powers of two and at least 2.
module data_cache #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    data_cache_if.slave bus
);
    localparam int OFF_B  = 3;
    localparam int WORD_B = $clog2(LINE_WORDS);
    localparam int IDX_B  = $clog2(SETS);
    localparam int LOW_B  = OFF_B + WORD_B;
    localparam int TAG_W  = ADDR_W - LOW_B - IDX_B;
    localparam logic [WORD_B-1:0] LAST_BEAT = WORD_B'(LINE_WORDS - 1);
    localparam logic [WORD_B-1:0] ONE_BEAT  = WORD_B'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FILL  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [SETS-1:0]     valid_q;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [DATA_W-1:0]   data_q [SETS][LINE_WORDS];
    logic [WORD_B-1:0]   beat_q;
    logic [ADDR_W-1:0]   fill_base_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                wr_ack_q;

    // Address fields
    logic [IDX_B-1:0]    rd_idx_s, fill_idx_s, wr_idx_s;
    logic [TAG_W-1:0]    rd_tag_s, fill_tag_s, wr_tag_s;
    logic [WORD_B-1:0]   rd_word_s, wr_word_s;
    logic                unused_ok_s;

    // Control strobes from the FSM
    logic                hit_s, wr_hit_s;
    logic                take_wr_s, start_fill_s, fill_beat_s, fill_last_s, wr_done_s;
    logic                mem_req_s, mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic [DATA_W-1:0]   rd_data_s;

    assign rd_word_s  = bus.rd_addr[OFF_B +: WORD_B];
    assign rd_idx_s   = bus.rd_addr[LOW_B +: IDX_B];
    assign rd_tag_s   = bus.rd_addr[ADDR_W-1 -: TAG_W];
    assign fill_idx_s = fill_base_q[LOW_B +: IDX_B];
    assign fill_tag_s = fill_base_q[ADDR_W-1 -: TAG_W];
    assign wr_word_s  = wr_addr_q[OFF_B +: WORD_B];
    assign wr_idx_s   = wr_addr_q[LOW_B +: IDX_B];
    assign wr_tag_s   = wr_addr_q[ADDR_W-1 -: TAG_W];
    // Byte offset of a word-aligned load carries no information
    assign unused_ok_s = ^bus.rd_addr[OFF_B-1:0];

    // Load hit: valid line with matching tag, except the set being refilled
    always_comb begin
        hit_s = 1'b0;
        if (bus.rd_req && valid_q[rd_idx_s] && (tag_q[rd_idx_s] == rd_tag_s)) begin
            if ((state_q == S_FILL) && (rd_idx_s == fill_idx_s)) begin
                hit_s = 1'b0;
            end else begin
                hit_s = 1'b1;
            end
        end else begin
            hit_s = 1'b0;
        end
    end

    // Store hit test against the latched store address
    always_comb begin
        wr_hit_s = 1'b0;
        if (valid_q[wr_idx_s] && (tag_q[wr_idx_s] == wr_tag_s)) begin
            wr_hit_s = 1'b1;
        end else begin
            wr_hit_s = 1'b0;
        end
    end

    // Hit data is forced to zero whenever no hit is reported
    always_comb begin
        rd_data_s = '0;
        if (hit_s) begin
            rd_data_s = data_q[rd_idx_s][rd_word_s];
        end else begin
            rd_data_s = '0;
        end
    end

    // FSM next state, memory bus drive and control strobes
    always_comb begin
        state_d      = state_q;
        take_wr_s    = 1'b0;
        start_fill_s = 1'b0;
        fill_beat_s  = 1'b0;
        fill_last_s  = 1'b0;
        wr_done_s    = 1'b0;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        mem_addr_s   = '0;
        mem_wdata_s  = '0;
        case (state_q)
            S_IDLE: begin
                // A store still high during its own ack cycle is already done
                if (bus.wr_req && !wr_ack_q) begin
                    state_d   = S_WRITE;
                    take_wr_s = 1'b1;
                end else if (bus.rd_req && !hit_s) begin
                    state_d      = S_FILL;
                    start_fill_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                mem_req_s   = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = wr_addr_q;
                mem_wdata_s = wr_data_q;
                if (bus.mem_ack) begin
                    wr_done_s = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_FILL: begin
                mem_req_s  = 1'b1;
                mem_addr_s = fill_base_q |
                             {{(ADDR_W-LOW_B){1'b0}}, beat_q, {OFF_B{1'b0}}};
                if (bus.mem_ack) begin
                    fill_beat_s = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        fill_last_s = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state; reset aborts any transaction and invalidates every line
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            beat_q      <= '0;
            fill_base_q <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ack_q <= wr_done_s;
            if (take_wr_s) begin
                wr_addr_q <= bus.wr_addr;
                wr_data_q <= bus.wr_data;
            end
            if (start_fill_s) begin
                fill_base_q       <= {bus.rd_addr[ADDR_W-1:LOW_B], {LOW_B{1'b0}}};
                valid_q[rd_idx_s] <= 1'b0;
                beat_q            <= '0;
            end
            if (fill_beat_s) begin
                beat_q <= beat_q + ONE_BEAT;
            end
            if (fill_last_s) begin
                valid_q[fill_idx_s] <= 1'b1;
            end
        end
    end

    // Tag and data arrays: fill beats and write-through store hits
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fill_beat_s) begin
                data_q[fill_idx_s][beat_q] <= bus.mem_rdata;
            end
            if (fill_last_s) begin
                tag_q[fill_idx_s] <= fill_tag_s;
            end
            if (wr_done_s && wr_hit_s) begin
                data_q[wr_idx_s][wr_word_s] <= wr_data_q;
            end
        end
    end

    assign bus.rd_ready  = hit_s;
    assign bus.rd_data   = rd_data_s;
    assign bus.wr_ack    = wr_ack_q;
    assign bus.mem_req   = mem_req_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: the bench plays both the memory stage and a
// zero-wait main memory. Inputs change on the falling edge; outputs are
// sampled 1 ns later, well away from the rising edge.
module tb_data_cache;
    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    data_cache_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    data_cache #(.ADDR_W(64), .DATA_W(64), .SETS(16), .LINE_WORDS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Bounded wait for a memory request; reports how many cycles it took
    task automatic wait_mem(input string tag, output int waited);
        waited = 0;
        #1;
        while (bus.mem_req !== 1'b1 && waited < 20) begin
            tick();
            #1;
            waited++;
        end
        check_eq({tag, "_mem_req"}, {63'd0, bus.mem_req}, 64'd1);
    endtask

    // Serve nbeats fill reads of the line at base with data d0, d0+1, ...
    task automatic fill_line(input string tag, input logic [63:0] base,
                             input logic [63:0] d0, input int nbeats);
        int w;
        for (int i = 0; i < nbeats; i++) begin
            wait_mem(tag, w);
            check_eq({tag, "_wait"}, 64'(w), 64'd0);
            check_eq({tag, "_we"}, {63'd0, bus.mem_we}, 64'd0);
            check_eq({tag, "_addr"}, bus.mem_addr, base + 64'(i * 8));
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = d0 + 64'(i);
            tick();
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 64'd0;
        end
    endtask

    // Full store handshake; req_after is the expected mem_req once it is done
    task automatic store(input string tag, input logic [63:0] addr,
                         input logic [63:0] data, input logic req_after);
        int w;
        bus.wr_req  = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        #1;
        check_eq({tag, "_idle_req"}, {63'd0, bus.mem_req}, 64'd0);
        tick();
        wait_mem(tag, w);
        check_eq({tag, "_wait"}, 64'(w), 64'd0);
        check_eq({tag, "_we"}, {63'd0, bus.mem_we}, 64'd1);
        check_eq({tag, "_addr"}, bus.mem_addr, addr);
        check_eq({tag, "_wdata"}, bus.mem_wdata, data);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        #1;
        check_eq({tag, "_ack"}, {63'd0, bus.wr_ack}, 64'd1);
        check_eq({tag, "_ack_req"}, {63'd0, bus.mem_req}, 64'd0);
        tick();
        bus.wr_req = 1'b0;
        #1;
        check_eq({tag, "_ack_pulse"}, {63'd0, bus.wr_ack}, 64'd0);
        check_eq({tag, "_req_after"}, {63'd0, bus.mem_req}, {63'd0, req_after});
    endtask

    initial begin
        bus.rd_req    = 1'b0;
        bus.rd_addr   = 64'd0;
        bus.wr_req    = 1'b0;
        bus.wr_addr   = 64'd0;
        bus.wr_data   = 64'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 64'd0;
        reset         = 1'b1;
        tick();
        tick();
        #1;
        check_eq("rst_rd_ready", {63'd0, bus.rd_ready}, 64'd0);
        check_eq("rst_rd_data", bus.rd_data, 64'd0);
        check_eq("rst_wr_ack", {63'd0, bus.wr_ack}, 64'd0);
        check_eq("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
        check_eq("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
        check_eq("rst_mem_addr", bus.mem_addr, 64'd0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 64'd0);
        reset = 1'b0;

        // Cold miss on 0x100
        bus.rd_req  = 1'b1;
        bus.rd_addr = 64'h100;
        #1;
        check_eq("cold_miss_ready", {63'd0, bus.rd_ready}, 64'd0);
        check_eq("cold_miss_data", bus.rd_data, 64'd0);
        check_eq("cold_miss_req", {63'd0, bus.mem_req}, 64'd0);
        tick();
        fill_line("cold", 64'h100, 64'hA0, 4);
        #1;
        check_eq("cold_done_ready", {63'd0, bus.rd_ready}, 64'd1);
        check_eq("cold_done_data", bus.rd_data, 64'hA0);
        check_eq("cold_done_req", {63'd0, bus.mem_req}, 64'd0);
        bus.rd_addr = 64'h110;
        #1;
        check_eq("hit110_ready", {63'd0, bus.rd_ready}, 64'd1);
        check_eq("hit110_data", bus.rd_data, 64'hA2);
        tick();
        #1;
        check_eq("hit110_no_req", {63'd0, bus.mem_req}, 64'd0);
        bus.rd_req = 1'b0;

        // Store hit updates the resident line
        store("st_hit", 64'h108, 64'hBEEF, 1'b0);
        bus.rd_req  = 1'b1;
        bus.rd_addr = 64'h108;
        #1;
        check_eq("st_hit_rd_ready", {63'd0, bus.rd_ready}, 64'd1);
        check_eq("st_hit_rd_data", bus.rd_data, 64'hBEEF);
        bus.rd_req = 1'b0;

        // Store miss does not allocate
        store("st_miss", 64'h400, 64'h1234, 1'b0);
        bus.rd_req  = 1'b1;
        bus.rd_addr = 64'h400;
        #1;
        check_eq("st_miss_rd_ready", {63'd0, bus.rd_ready}, 64'd0);
        tick();
        fill_line("fill400", 64'h400, 64'h1234, 4);
        #1;
        check_eq("fill400_ready", {63'd0, bus.rd_ready}, 64'd1);
        check_eq("fill400_data", bus.rd_data, 64'h1234);
        bus.rd_req = 1'b0;

        // Conflict eviction: 0x300 shares the set of 0x100
        bus.rd_req  = 1'b1;
        bus.rd_addr = 64'h300;
        #1;
        check_eq("conf_miss_ready", {63'd0, bus.rd_ready}, 64'd0);
        tick();
        fill_line("conf", 64'h300, 64'hD0, 4);
        #1;
        check_eq("conf_ready", {63'd0, bus.rd_ready}, 64'd1);
        check_eq("conf_data", bus.rd_data, 64'hD0);
        bus.rd_addr = 64'h100;
        #1;
        check_eq("evicted_ready", {63'd0, bus.rd_ready}, 64'd0);
        tick();

        // Reset after two of four fill beats
        fill_line("part", 64'h100, 64'hA0, 2);
        reset = 1'b1;
        tick();
        #1;
        check_eq("rst_fill_req", {63'd0, bus.mem_req}, 64'd0);
        check_eq("rst_fill_ready", {63'd0, bus.rd_ready}, 64'd0);
        check_eq("rst_fill_wr_ack", {63'd0, bus.wr_ack}, 64'd0);
        reset = 1'b0;
        tick();
        fill_line("refill", 64'h100, 64'hA0, 4);
        #1;
        check_eq("refill_ready", {63'd0, bus.rd_ready}, 64'd1);
        check_eq("refill_data", bus.rd_data, 64'hA0);
        bus.rd_addr = 64'h118;
        #1;
        check_eq("refill_data118", bus.rd_data, 64'hA3);
        bus.rd_req = 1'b0;

        // Store and miss presented together: write beat goes first
        bus.rd_req  = 1'b1;
        bus.rd_addr = 64'h600;
        store("st_first", 64'h500, 64'h55, 1'b1);
        fill_line("after_st", 64'h600, 64'hE0, 4);
        #1;
        check_eq("after_st_ready", {63'd0, bus.rd_ready}, 64'd1);
        check_eq("after_st_data", bus.rd_data, 64'hE0);
        bus.rd_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
